// File: rtl/dm_pkg.sv
// Shared types and constants for the MEM-stage data responder.
// Holds the FSM state encoding, byte-enable patterns and the wait-counter width.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;

  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = (1 << CNT_W) - 1;

endpackage

// File: rtl/dm_array.sv
// Word-organised data storage with per-lane write enables and a registered read port.
// The read register clears whenever no read is strobed, so it doubles as the response data.
module dm_array #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Reset keeps a read sampled on a reset-coincident edge from leaking out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[addr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Stallable data-memory responder: one request at a time, WAIT wait states, then a
// single-cycle response carrying load data or an out-of-range error.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int WAIT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  if (WAIT < 0 || WAIT > WAIT_MAX) begin : g_bad_wait
    $error("dm_responder: WAIT must be within 0..%0d", WAIT_MAX);
  end
  if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
    $error("dm_responder: ADDR_W must be within 1..29");
  end

  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT == 0) ? '0 : CNT_W'(WAIT - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_ready_q, resp_valid_q, resp_err_q;
  logic              we_q, err_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              in_range;
  logic              commit_d;
  logic              cur_we_d, cur_err_d;
  logic [3:0]        cur_be_d;
  logic [ADDR_W-1:0] cur_addr_d;
  logic [31:0]       cur_wdata_d;
  logic              unused_addr_lsbs;

  assign in_range         = (req_addr[31:ADDR_W+2] == '0);
  assign unused_addr_lsbs = ^req_addr[1:0];

  // With WAIT=0 the commit edge is the acceptance edge, so the live request is used.
  always_comb begin
    commit_d    = 1'b0;
    cur_we_d    = we_q;
    cur_err_d   = err_q;
    cur_be_d    = be_q;
    cur_addr_d  = addr_q;
    cur_wdata_d = wdata_q;
    if (state_q == IDLE) begin
      commit_d    = req_valid && (WAIT == 0);
      cur_we_d    = req_we;
      cur_err_d   = ~in_range;
      cur_be_d    = req_be;
      cur_addr_d  = req_addr[ADDR_W+1:2];
      cur_wdata_d = req_wdata;
    end else if (state_q == BUSY) begin
      commit_d = (cnt_q == '0);
    end
    commit_d = commit_d & reset;
  end

  dm_array #(.ADDR_W(ADDR_W)) u_array (
    .clk_i   (clk),
    .rst_ni  (reset),
    .wr_en_i (commit_d & cur_we_d & ~cur_err_d),
    .rd_en_i (commit_d & ~cur_we_d & ~cur_err_d),
    .be_i    (cur_be_d),
    .addr_i  (cur_addr_d),
    .wdata_i (cur_wdata_d),
    .rdata_o (resp_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            be_q        <= req_be;
            addr_q      <= req_addr[ADDR_W+1:2];
            wdata_q     <= req_wdata;
            err_q       <= ~in_range;
            req_ready_q <= 1'b0;
            if (WAIT == 0) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= ~in_range;
            end else begin
              cnt_q   <= WAIT_LOAD;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed scenarios plus randomized accesses
// compared against a word-level memory model.
module tb_dm_responder;
  import dm_pkg::*;

  localparam int ADDR_W = 12;
  localparam int WAIT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = 4'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [int];

  always #5 clk = ~clk;

  dm_responder #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_be     (req_be),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // Memory of words; an access outside 2^ADDR_W words only reports an error.
  function automatic void model_access(input logic we, input logic [3:0] be,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
    int idx;
    logic [31:0] word;
    err   = (addr >> (ADDR_W + 2)) != 0;
    rdata = 32'h0;
    if (err) return;
    idx  = int'(addr >> 2);
    word = model.exists(idx) ? model[idx] : 32'h0;
    if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
      model[idx] = word;
    end else begin
      rdata = word;
    end
  endfunction

  task automatic access(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat, output logic ready_after,
                        output logic trail_ok, output bit tout);
    int n;
    tout = 0; rdata = 32'h0; err = 1'b0; lat = 0; ready_after = 1'b1; trail_ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin tout = 1; req_valid = 1'b0; return; end
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_be = 4'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    ready_after = req_ready;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
    if (lat >= 50) begin tout = 1; return; end
    rdata = resp_rdata;
    err   = resp_err;
    @(negedge clk);
    trail_ok = (resp_valid === 1'b0) && (resp_rdata === 32'h0) && (resp_err === 1'b0);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata got %h want 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err got %b want 0", resp_err); end
    reset = 1'b1;
  endtask

  task automatic test_load_basic();
    logic [31:0] rd, erd; logic er, eer, rdy, tr; int lat; bit to;
    model_access(1'b0, BE_WORD, 32'h10, 32'h0, erd, eer);
    access(1'b0, BE_WORD, 32'h10, 32'h0, rd, er, lat, rdy, tr, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL basic_timeout got 1 want 0"); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL basic_ready_drop got %b want 0", rdy); end
    checks++; if (lat != WAIT + 1) begin errors++; $display("[TB] FAIL basic_latency got %0d want %0d", lat, WAIT + 1); end
    checks++; if (rd !== 32'h0 || rd !== erd) begin errors++; $display("[TB] FAIL basic_rdata got %h want 0", rd); end
    checks++; if (er !== 1'b0 || er !== eer) begin errors++; $display("[TB] FAIL basic_err got %b want 0", er); end
    checks++; if (tr !== 1'b1) begin errors++; $display("[TB] FAIL basic_one_cycle got %b want 1", tr); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, erd; logic er, eer, rdy, tr; int lat; bit to;
    model_access(1'b1, BE_WORD, 32'h40, 32'hDEAD_BEEF, erd, eer);
    access(1'b1, BE_WORD, 32'h40, 32'hDEAD_BEEF, rd, er, lat, rdy, tr, to);
    checks++; if (to || rd !== 32'h0 || er !== 1'b0) begin errors++; $display("[TB] FAIL store_resp got %h/%b want 0/0", rd, er); end
    checks++; if (tr !== 1'b1) begin errors++; $display("[TB] FAIL store_one_cycle got %b want 1", tr); end
    model_access(1'b0, BE_WORD, 32'h40, 32'h0, erd, eer);
    access(1'b0, BE_WORD, 32'h40, 32'h0, rd, er, lat, rdy, tr, to);
    checks++; if (to || rd !== 32'hDEAD_BEEF || rd !== erd) begin errors++; $display("[TB] FAIL store_readback got %h want deadbeef", rd); end
    checks++; if (lat != WAIT + 1) begin errors++; $display("[TB] FAIL store_latency got %0d want %0d", lat, WAIT + 1); end
  endtask

  task automatic test_byte_lane();
    logic [31:0] rd, erd; logic er, eer, rdy, tr; int lat; bit to;
    model_access(1'b1, BE_WORD, 32'h44, 32'h1122_3344, erd, eer);
    access(1'b1, BE_WORD, 32'h44, 32'h1122_3344, rd, er, lat, rdy, tr, to);
    model_access(1'b1, BE_BYTE2, 32'h44, 32'h00AB_0000, erd, eer);
    access(1'b1, BE_BYTE2, 32'h46, 32'h00AB_0000, rd, er, lat, rdy, tr, to);
    model_access(1'b0, BE_BYTE0, 32'h44, 32'h0, erd, eer);
    access(1'b0, BE_BYTE0, 32'h44, 32'h0, rd, er, lat, rdy, tr, to);
    checks++; if (to || rd !== 32'h11AB_3344 || rd !== erd) begin errors++; $display("[TB] FAIL lane_merge got %h want 11ab3344", rd); end
    model_access(1'b1, BE_HALF0, 32'h48, 32'hFFFF_5A5A, erd, eer);
    access(1'b1, BE_HALF0, 32'h48, 32'hFFFF_5A5A, rd, er, lat, rdy, tr, to);
    model_access(1'b0, BE_WORD, 32'h48, 32'h0, erd, eer);
    access(1'b0, BE_WORD, 32'h48, 32'h0, rd, er, lat, rdy, tr, to);
    checks++; if (to || rd !== 32'h0000_5A5A || rd !== erd) begin errors++; $display("[TB] FAIL half_write got %h want 00005a5a", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd, erd; logic er, eer, rdy, tr; int lat; bit to;
    access(1'b0, BE_WORD, 32'h0001_0000, 32'h0, rd, er, lat, rdy, tr, to);
    checks++; if (to || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("[TB] FAIL oor_load got %h/%b want 0/1", rd, er); end
    checks++; if (tr !== 1'b1) begin errors++; $display("[TB] FAIL oor_err_clear got %b want 1", tr); end
    access(1'b1, BE_WORD, 32'h0001_0000, 32'hFFFF_FFFF, rd, er, lat, rdy, tr, to);
    checks++; if (to || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("[TB] FAIL oor_store got %h/%b want 0/1", rd, er); end
    access(1'b0, BE_WORD, 32'h0, 32'h0, rd, er, lat, rdy, tr, to);
    checks++; if (to || er !== 1'b0 || rd !== 32'h0) begin errors++; $display("[TB] FAIL oor_no_alias got %h/%b want 0/0", rd, er); end
    access(1'b1, 4'b0000, 32'h40, 32'h1234_5678, rd, er, lat, rdy, tr, to);
    checks++; if (to || er !== 1'b0) begin errors++; $display("[TB] FAIL be0_err got %b want 0", er); end
    access(1'b0, BE_WORD, 32'h40, 32'h0, rd, er, lat, rdy, tr, to);
    checks++; if (to || rd !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL be0_nowrite got %h want deadbeef", rd); end
    access(1'b0, BE_WORD, 32'h0000_3FFC, 32'h0, rd, er, lat, rdy, tr, to);
    checks++; if (to || er !== 1'b0) begin errors++; $display("[TB] FAIL top_word_err got %b want 0", er); end
    access(1'b0, BE_WORD, 32'h0000_4000, 32'h0, rd, er, lat, rdy, tr, to);
    checks++; if (to || er !== 1'b1) begin errors++; $display("[TB] FAIL first_oor_err got %b want 1", er); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expq[$];
    int acc_cyc[$];
    logic [31:0] erd; logic eer;
    int naccept = 0, nresp = 0;
    bit adv = 0, sel = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_be = BE_WORD; req_addr = 32'h40;
    for (int c = 0; c < 100; c++) begin
      if (adv) begin
        adv = 0;
        if (naccept == 8) req_valid = 1'b0;
        else begin sel = ~sel; req_addr = sel ? 32'h44 : 32'h40; end
      end
      if (resp_valid === 1'b1) begin
        nresp++;
        checks++;
        if (expq.size() == 0) begin errors++; $display("[TB] FAIL b2b_extra_resp got %h want none", resp_rdata); end
        else begin
          erd = expq.pop_front();
          if (resp_rdata !== erd) begin errors++; $display("[TB] FAIL b2b_rdata got %h want %h", resp_rdata, erd); end
        end
      end
      if (req_valid && req_ready === 1'b1) begin
        model_access(1'b0, BE_WORD, req_addr, 32'h0, erd, eer);
        expq.push_back(erd);
        acc_cyc.push_back(c);
        naccept++;
        adv = 1;
      end
      if (!req_valid && !adv && expq.size() == 0) break;
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++; if (naccept != 8) begin errors++; $display("[TB] FAIL b2b_accepts got %0d want 8", naccept); end
    checks++; if (nresp != naccept) begin errors++; $display("[TB] FAIL b2b_resps got %0d want %0d", nresp, naccept); end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != WAIT + 2) begin
        errors++; $display("[TB] FAIL b2b_spacing got %0d want %0d", acc_cyc[i] - acc_cyc[i-1], WAIT + 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, rdy, tr; int lat, n, seen; bit to;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_be = BE_WORD; req_addr = 32'h80; req_wdata = 32'hCAFE_F00D;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ctrl got %b%b want 10", req_ready, resp_valid); end
    checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_data got %h/%b want 0/0", resp_rdata, resp_err); end
    seen = 0;
    repeat (3) begin @(negedge clk); if (resp_valid !== 1'b0) seen++; end
    reset = 1'b1;
    repeat (5) begin @(negedge clk); if (resp_valid !== 1'b0) seen++; end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL midrst_no_resp got %0d want 0", seen); end
    access(1'b0, BE_WORD, 32'h80, 32'h0, rd, er, lat, rdy, tr, to);
    checks++; if (to || rd !== 32'h0 || er !== 1'b0) begin errors++; $display("[TB] FAIL midrst_array got %h want 0", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wdata; logic er, eer, rdy, tr, we; logic [3:0] be;
    int lat; bit to;
    for (int i = 0; i < 40; i++) begin
      we    = 1'($urandom_range(0, 1));
      be    = 4'($urandom);
      wdata = $urandom;
      if ($urandom_range(0, 7) == 0) addr = $urandom | (32'h1 << (ADDR_W + 2 + $urandom_range(0, 15)));
      else addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)) | 32'h100;
      model_access(we, be, addr, wdata, erd, eer);
      access(we, be, addr, wdata, rd, er, lat, rdy, tr, to);
      checks++; if (to || rd !== erd) begin errors++; $display("[TB] FAIL rand_rdata addr %h got %h want %h", addr, rd, erd); end
      checks++; if (er !== eer) begin errors++; $display("[TB] FAIL rand_err addr %h got %b want %b", addr, er, eer); end
      checks++; if (lat != WAIT + 1 || tr !== 1'b1) begin errors++; $display("[TB] FAIL rand_timing got %0d/%b want %0d/1", lat, tr, WAIT + 1); end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load_basic();
    test_store_load();
    test_byte_lane();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage data accesses.
- Accepts one load/store request at a time over a valid/ready handshake and inserts WAIT configurable wait states.
- Commits byte-lane writes, or returns the addressed word, with an out-of-range error flag.
- Replaces the single-cycle data memory when the core moves to a stallable memory port. The requester drives PIPE_STALL from req_ready and resp_valid.

Parameters:
ADDR_W, 12, word-address bits; capacity 2^ADDR_W words (16 KiB default)
WAIT, 2, wait states between acceptance and response (0..15)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low (0 = reset asserted)
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_be  input  4  byte enables, bit i = byte lane i (bits 8i+7:8i)
req_addr  input  32  byte address; bits 1:0 ignored (lanes selected by req_be)
req_wdata  input  32  store data, lane-aligned
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  32  load data (full word); 0 for stores and errors
resp_err  output  1  address out of range; valid with resp_valid

Behaviour:
- Reset values (asynchronous assertion): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
- Array contents are zero at time 0. Reset does not affect array contents.
- FSM states:
  - IDLE: req_ready=1. On req_valid at a rising edge, latch we/be/addr/wdata and evaluate the range check. If WAIT=0, go to RESP; otherwise load the counter with WAIT-1 and go to BUSY.
  - BUSY: req_ready=0. Decrement the counter each cycle. At count 0, go to RESP.
  - RESP: req_ready=0, resp_valid=1 for exactly this cycle. Next state is always IDLE.
- Range check: in range iff req_addr[31:ADDR_W+2]==0. Out of range means resp_err=1, no write, resp_rdata=0.
- Latency: a request accepted at edge N gives resp_valid high in cycle N+WAIT+1. Earliest next acceptance is edge N+WAIT+2, so throughput is one access per WAIT+2 cycles.
- Store commit: on the edge entering RESP, only lanes with req_be[i]=1 are written. be=0000 writes nothing and is not an error. A store responds with resp_rdata=0.
- Load data: the word at addr[ADDR_W+1:2] is sampled on the edge entering RESP, independent of be. The requester performs lane extraction and sign/zero extension.
- Ordering: a load issued after a store to the same word returns the stored data, because accesses are strictly serialized.
- req_valid during BUSY or RESP is ignored (not accepted). The requester holds the request until it sees req_ready high at an edge.
- resp_rdata and resp_err return to 0 in every cycle where resp_valid=0.
- Reset mid-operation: returns immediately to IDLE.
  - A store in BUSY is aborted and the array is unchanged.
  - A store whose commit edge coincides with reset assertion is also discarded, because asynchronous reset wins.
  - No response is generated for the aborted request.
- Counter width is 4 bits. WAIT>15 is an illegal parameterization; elaboration fails via a static check.

Decomposition:
- Shared package dm_pkg:
  - state enum {IDLE, BUSY, RESP}
  - byte-enable constants BE_WORD=4'b1111, BE_HALF0=4'b0011, BE_HALF1=4'b1100, BE_BYTE0..BE_BYTE3
  - localparam for counter width
- One sub-module dm_array:
  - 2^ADDR_W x 32 storage, synchronous read, 4-lane byte-write enable
  - write and read-sample ports driven by dm_responder's RESP-entry strobe

Test Plan:
1. Reset release, WAIT=2, load addr 0x0000_0010 -> req_ready falls the cycle after acceptance; resp_valid at N+3; resp_rdata=0x0000_0000, resp_err=0.
2. Store be=1111 wdata=0xDEAD_BEEF to 0x0000_0040, then load 0x0000_0040 -> second response resp_rdata=0xDEAD_BEEF. Store response rdata=0.
3. Store be=0100 wdata=0x00AB_0000 over word 0x1122_3344 at 0x0000_0044, then load -> 0x11AB_3344.
4. Load 0x0001_0000 (ADDR_W=12) -> resp_err=1, resp_rdata=0. A following store there with be=1111 -> resp_err=1 and no array change anywhere (spot-check 0x0000_0000).
5. req_valid held high continuously with alternating addresses -> exactly one acceptance per 4 cycles (WAIT=2); no request lost or duplicated.
6. Assert reset during BUSY of a store of 0xCAFE_F00D to 0x0000_0080 -> no resp_valid; outputs at reset values. After release, load 0x0000_0080 returns the prior value 0x0000_0000.
